// File: rtl/systolic_drain.sv
// Drain stage: de-skews systolic column outputs into rows and buffers them in a FWFT FIFO.
// Optional: define SYSTOLIC_DRAIN_RELU_EN to clamp negative elements to zero at FIFO write.
module systolic_drain #(
    parameter int DATAWIDTH_output = 32,
    parameter int N_SIZE           = 32,
    parameter int LATENCY          = 32,
    parameter int MAX_ROWS         = 256,
    parameter int FIFO_DEPTH       = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [$clog2(MAX_ROWS+1)-1:0]           num_rows,
    input  logic [N_SIZE-1:0][DATAWIDTH_output-1:0] matrix_C,
    output logic [N_SIZE-1:0][DATAWIDTH_output-1:0] out_row,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    busy,
    output logic                                    tile_done,
    output logic                                    overflow
);

    localparam int DW       = DATAWIDTH_output;
    localparam int NRW      = $clog2(MAX_ROWS + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int WAIT_CYC = LATENCY + N_SIZE - 1;
    localparam int WCW      = $clog2(WAIT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [NRW-1:0]   r_num;
    logic [NRW-1:0]   r_row;
    logic [WCW-1:0]   r_wait;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;

    logic [N_SIZE-1:0][DW-1:0] r_mem [FIFO_DEPTH];

    logic [DW-1:0]             w_aligned [N_SIZE];
    logic [N_SIZE-1:0][DW-1:0] w_wr_row;
    logic                      w_empty;
    logic                      w_full;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_wr_en;
    logic                      w_drop;

    // Column k is delayed N_SIZE-1-k cycles so every column of a row lines up.
    genvar k;
    generate
        for (k = 0; k < N_SIZE - 1; k++) begin : g_dly
            localparam int D = N_SIZE - 1 - k;
            logic [DW-1:0] r_sh [D];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < D; s++) r_sh[s] <= '0;
                end else begin
                    r_sh[0] <= matrix_C[k];
                    for (int s = 1; s < D; s++) r_sh[s] <= r_sh[s-1];
                end
            end
            assign w_aligned[k] = r_sh[D-1];
        end
    endgenerate

    assign w_aligned[N_SIZE-1] = matrix_C[N_SIZE-1];

    always_comb begin
        w_wr_row = '0;
        for (int c = 0; c < N_SIZE; c++) begin
`ifdef SYSTOLIC_DRAIN_RELU_EN
            w_wr_row[c] = w_aligned[c][DW-1] ? '0 : w_aligned[c];
`else
            w_wr_row[c] = w_aligned[c];
`endif
        end
    end

    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop   = !w_empty && out_ready;
    assign w_push  = (r_state == S_CAPTURE) && (r_row != r_num);
    // A full FIFO still accepts a row when the head leaves in the same cycle.
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    assign out_valid = !w_empty;
    assign out_row   = w_empty ? '0 : r_mem[r_rd[AW-1:0]];
    assign busy      = r_busy;
    assign tile_done = r_done;
    assign overflow  = r_ovf;

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr[AW-1:0]] <= w_wr_row;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_num   <= '0;
            r_row   <= '0;
            r_wait  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_wr    <= '0;
            r_rd    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_wr_en) r_wr <= r_wr + 1'b1;
            if (w_pop)   r_rd <= r_rd + 1'b1;
            if (w_drop)  r_ovf <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num  <= num_rows;
                        r_row  <= '0;
                        r_busy <= 1'b1;
                        if (num_rows == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_ovf <= 1'b0;
                            // The counter holds the cycles left until the row-0 capture.
                            if (WAIT_CYC <= 1) begin
                                r_state <= S_CAPTURE;
                            end else begin
                                r_wait  <= WCW'(WAIT_CYC - 1);
                                r_state <= S_WAIT;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wait <= WCW'(1)) begin
                        r_wait  <= '0;
                        r_state <= S_CAPTURE;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (r_row == r_num) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain with N_SIZE=4, LATENCY=4, FIFO_DEPTH=8.
// Cycle t of a tile is the cycle whose ending posedge samples start at t=0.
module tb_systolic_drain;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [8:0]          num_rows;
    logic [3:0][31:0]    matrix_C;
    logic [3:0][31:0]    out_row;
    logic                out_valid;
    logic                out_ready;
    logic                busy;
    logic                tile_done;
    logic                overflow;

    int checks   = 0;
    int failures = 0;

    systolic_drain #(
        .DATAWIDTH_output(32),
        .N_SIZE(4),
        .LATENCY(4),
        .MAX_ROWS(256),
        .FIFO_DEPTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .num_rows(num_rows),
        .matrix_C(matrix_C),
        .out_row(out_row),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .tile_done(tile_done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0][31:0] exp_row(input int r);
        logic [3:0][31:0] v;
        for (int k = 0; k < 4; k++) v[k] = 32'(16 * r + k);
        return v;
    endfunction

    // Element (r,k) is presented at cycle 4+r+k.
    task automatic drive_skew(input int t, input int nrows);
        for (int k = 0; k < 4; k++) begin
            int r;
            r = t - 4 - k;
            matrix_C[k] = (r >= 0 && r < nrows) ? 32'(16 * r + k) : 32'd0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        num_rows = '0;
        matrix_C = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, busy, tile_done, overflow} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {out_valid, busy, tile_done, overflow});
        end
        checks++;
        if (out_row !== '0) begin
            failures++;
            $display("FAIL reset_row got=%h exp=0", out_row);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        for (int t = 0; t < 14; t++) begin
            logic             ev;
            logic [3:0][31:0] er;
            ev = (t >= 8 && t <= 10);
            er = ev ? exp_row(t - 8) : '0;
            checks++;
            if (out_valid !== ev) begin
                failures++;
                $display("FAIL basic_valid t=%0d got=%b exp=%b", t, out_valid, ev);
            end
            checks++;
            if (out_row !== er) begin
                failures++;
                $display("FAIL basic_row t=%0d got=%h exp=%h", t, out_row, er);
            end
            checks++;
            if (tile_done !== (t == 11)) begin
                failures++;
                $display("FAIL basic_done t=%0d got=%b exp=%b", t, tile_done, t == 11);
            end
            checks++;
            if (busy !== (t >= 1 && t <= 11)) begin
                failures++;
                $display("FAIL basic_busy t=%0d got=%b exp=%b", t, busy, t >= 1 && t <= 11);
            end
            checks++;
            if (overflow !== 1'b0) begin
                failures++;
                $display("FAIL basic_ovf t=%0d got=%b exp=0", t, overflow);
            end
            start = (t == 0);
            num_rows = 9'd3;
            out_ready = 1'b1;
            drive_skew(t, 3);
            @(negedge clk);
        end
        start = 1'b0;
        matrix_C = '0;
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int got;
        for (int t = 0; t < 23; t++) begin
            checks++;
            if (overflow !== (t >= 16)) begin
                failures++;
                $display("FAIL ovf_flag t=%0d got=%b exp=%b", t, overflow, t >= 16);
            end
            checks++;
            if (out_valid !== (t >= 8)) begin
                failures++;
                $display("FAIL ovf_valid t=%0d got=%b exp=%b", t, out_valid, t >= 8);
            end
            checks++;
            if (tile_done !== (t == 20)) begin
                failures++;
                $display("FAIL ovf_done t=%0d got=%b exp=%b", t, tile_done, t == 20);
            end
            if (t >= 8) begin
                checks++;
                if (out_row !== exp_row(0)) begin
                    failures++;
                    $display("FAIL ovf_head t=%0d got=%h exp=%h", t, out_row, exp_row(0));
                end
            end
            start = (t == 0);
            num_rows = 9'd12;
            out_ready = 1'b0;
            drive_skew(t, 12);
            @(negedge clk);
        end
        start = 1'b0;
        matrix_C = '0;
        got = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) begin
                checks++;
                if (out_row !== exp_row(got)) begin
                    failures++;
                    $display("FAIL ovf_drain i=%0d got=%h exp=%h", got, out_row, exp_row(got));
                end
                got++;
            end
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (got != 8) begin
            failures++;
            $display("FAIL ovf_count got=%0d exp=8", got);
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky got=%b exp=1", overflow);
        end
    endtask

    task automatic test_zero_rows();
        for (int t = 0; t < 5; t++) begin
            checks++;
            if (tile_done !== (t == 1)) begin
                failures++;
                $display("FAIL zero_done t=%0d got=%b exp=%b", t, tile_done, t == 1);
            end
            checks++;
            if (busy !== (t == 1)) begin
                failures++;
                $display("FAIL zero_busy t=%0d got=%b exp=%b", t, busy, t == 1);
            end
            checks++;
            if (out_valid !== 1'b0 || overflow !== 1'b1) begin
                failures++;
                $display("FAIL zero_valid_ovf t=%0d got=%b%b exp=01", t, out_valid, overflow);
            end
            start = (t == 0);
            num_rows = 9'd0;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_start_ignored();
        int dones;
        int valids;
        dones = 0;
        valids = 0;
        for (int t = 0; t < 22; t++) begin
            logic             ev;
            logic [3:0][31:0] er;
            ev = (t == 8 || t == 9);
            er = ev ? exp_row(t - 8) : '0;
            if (tile_done) dones++;
            if (out_valid) valids++;
            checks++;
            if (out_valid !== ev || out_row !== er) begin
                failures++;
                $display("FAIL ign_row t=%0d got=%b/%h exp=%b/%h", t, out_valid, out_row, ev, er);
            end
            checks++;
            if (tile_done !== (t == 10)) begin
                failures++;
                $display("FAIL ign_done t=%0d got=%b exp=%b", t, tile_done, t == 10);
            end
            if (t >= 1) begin
                checks++;
                if (overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL ign_ovf_clear t=%0d got=%b exp=0", t, overflow);
                end
            end
            start = (t == 0) || (t == 3);
            num_rows = (t == 0) ? 9'd2 : 9'd5;
            out_ready = 1'b1;
            drive_skew(t, 2);
            @(negedge clk);
        end
        start = 1'b0;
        matrix_C = '0;
        out_ready = 1'b0;
        checks++;
        if (dones != 1 || valids != 2) begin
            failures++;
            $display("FAIL ign_counts got=%0d/%0d exp=1/2", dones, valids);
        end
    endtask

    task automatic test_full_pushpop();
        int got;
        for (int t = 0; t < 23; t++) begin
            checks++;
            if (overflow !== 1'b0) begin
                failures++;
                $display("FAIL pp_ovf t=%0d got=%b exp=0", t, overflow);
            end
            checks++;
            if (tile_done !== (t == 20)) begin
                failures++;
                $display("FAIL pp_done t=%0d got=%b exp=%b", t, tile_done, t == 20);
            end
            if (t >= 15) begin
                logic [3:0][31:0] er;
                er = (t <= 18) ? exp_row(t - 15) : exp_row(4);
                checks++;
                if (out_valid !== 1'b1 || out_row !== er) begin
                    failures++;
                    $display("FAIL pp_head t=%0d got=%b/%h exp=1/%h", t, out_valid, out_row, er);
                end
            end
            start = (t == 0);
            num_rows = 9'd12;
            out_ready = (t >= 15 && t <= 18);
            drive_skew(t, 12);
            @(negedge clk);
        end
        start = 1'b0;
        matrix_C = '0;
        got = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) begin
                checks++;
                if (out_row !== exp_row(got + 4)) begin
                    failures++;
                    $display("FAIL pp_drain i=%0d got=%h exp=%h", got, out_row, exp_row(got + 4));
                end
                got++;
            end
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (got != 8) begin
            failures++;
            $display("FAIL pp_count got=%0d exp=8", got);
        end
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t < 11; t++) begin
            start = (t == 0);
            num_rows = 9'd6;
            out_ready = 1'b0;
            drive_skew(t, 6);
            if (t == 10) begin
                checks++;
                if (out_valid !== 1'b1 || out_row !== exp_row(0) || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL rmid_pre got=%b/%h/%b exp=1/%h/1", out_valid, out_row, busy, exp_row(0));
                end
                rst = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if ({out_valid, busy, tile_done, overflow} !== 4'b0000 || out_row !== '0) begin
            failures++;
            $display("FAIL rmid_post got=%b%b%b%b/%h exp=0000/0", out_valid, busy, tile_done, overflow, out_row);
        end
        rst = 1'b0;
        for (int t = 11; t < 22; t++) begin
            out_ready = 1'b1;
            drive_skew(t, 6);
            @(negedge clk);
            checks++;
            if ({out_valid, busy, tile_done} !== 3'b000) begin
                failures++;
                $display("FAIL rmid_idle t=%0d got=%b%b%b exp=000", t, out_valid, busy, tile_done);
            end
        end
        matrix_C = '0;
        out_ready = 1'b0;
    endtask

    task automatic test_element_values();
        logic [3:0][31:0] vals;
        logic [3:0][31:0] er;
        vals[0] = 32'hFFFF_FFFB;
        vals[1] = 32'd7;
        vals[2] = 32'h8000_0000;
        vals[3] = 32'h7FFF_FFFF;
`ifdef SYSTOLIC_DRAIN_RELU_EN
        er[0] = 32'd0;
        er[1] = 32'd7;
        er[2] = 32'd0;
        er[3] = 32'h7FFF_FFFF;
`else
        er = vals;
`endif
        for (int t = 0; t < 11; t++) begin
            checks++;
            if (out_valid !== (t == 8) || out_row !== ((t == 8) ? er : '0)) begin
                failures++;
                $display("FAIL elem t=%0d got=%b/%h exp=%b/%h", t, out_valid, out_row, t == 8, er);
            end
            checks++;
            if (tile_done !== (t == 9)) begin
                failures++;
                $display("FAIL elem_done t=%0d got=%b exp=%b", t, tile_done, t == 9);
            end
            start = (t == 0);
            num_rows = 9'd1;
            out_ready = 1'b1;
            for (int k = 0; k < 4; k++) matrix_C[k] = (t == 4 + k) ? vals[k] : 32'd0;
            @(negedge clk);
        end
        start = 1'b0;
        matrix_C = '0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_zero_rows();
        test_start_ignored();
        test_full_pushpop();
        test_reset_mid();
        test_element_values();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
